burst_write_master_fifo: RTL and testbench
==========================================

Name: burst_write_master_fifo

Overview:
Parametrised Avalon-MM burst write master that moves an arbitrary-length block of words from an internal show-ahead FIFO to memory. Producer logic pushes words through a simple write/full interface. The control side starts a transfer with a base address and a word length. The block splits the transfer into bursts of at most MAX_BURST words and issues each burst only when the FIFO already holds every word of it, so write data is never stalled mid-burst. It sits between pixel/stream producers and the SDRAM controller.

Parameters:
ADDRESS_WIDTH 32 byte address width
DATA_WIDTH 32 data width; 16, 32, 64 or 128
BYTE_ENABLE_WIDTH 4 DATA_WIDTH/8
BYTE_ENABLE_WIDTH_LOG2 2 log2(BYTE_ENABLE_WIDTH)
LENGTH_WIDTH 16 transfer length counter width, in words
MAX_BURST 8 maximum burst length in words; 1..2^(BURST_WIDTH-1)
BURST_WIDTH 4 must represent MAX_BURST
FIFO_DEPTH 16 power of 2, >= MAX_BURST
FIFO_AW 4 log2(FIFO_DEPTH)

Ports:
clk input 1 clock
reset input 1 asynchronous, active-high
master_address output ADDRESS_WIDTH burst start byte address
master_write output 1 Avalon write
master_writedata output DATA_WIDTH FIFO head word
master_burstcount output BURST_WIDTH current burst length
master_byteenable output BYTE_ENABLE_WIDTH all ones
master_waitrequest input 1 slave stall
ctrl_start input 1 one-cycle start pulse
ctrl_baseaddress input ADDRESS_WIDTH word-aligned start address
ctrl_length input LENGTH_WIDTH words to write
ctrl_busy output 1 transfer in progress
ctrl_done output 1 one-cycle completion pulse
user_write input 1 push user_writedata
user_writedata input DATA_WIDTH data word
user_full output 1 FIFO full
user_overflow output 1 sticky; set by a push while full

Behaviour:
- Reset, asynchronous: address 0, write 0, burstcount 0, busy 0, done 0, overflow 0. FIFO is emptied and its pointers and count are cleared. State goes to IDLE. Reset during a burst aborts it immediately, with no completion.
- master_byteenable is constant all ones. master_writedata is the FIFO head word, combinational from the read pointer.
- FIFO:
  - Accepts pushes in every state, so data can be prefilled before start.
  - A push while full is dropped and sets user_overflow, which only reset clears.
  - A simultaneous push and pop leaves the count unchanged.
  - user_full = (count == FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH. The count is FIFO_AW+1 bits wide.
- States: IDLE, WAIT_DATA, BURST.
- IDLE:
  - On ctrl_start with ctrl_length > 0: latch the address, set remaining = ctrl_length, busy = 1, go to WAIT_DATA.
  - On ctrl_start with ctrl_length = 0: done pulses in the next cycle, busy stays 0, no bus activity.
- WAIT_DATA:
  - beats = min(remaining, MAX_BURST).
  - When FIFO count >= beats: register master_burstcount = beats, master_write = 1, go to BURST. master_write rises the cycle after the condition holds.
- BURST:
  - A beat is accepted when master_write & ~master_waitrequest. Each accepted beat pops the FIFO and decrements the beat counter and remaining.
  - master_address and master_burstcount stay constant through the whole burst.
  - On the last beat: write <= 0, and address += beats*BYTE_ENABLE_WIDTH (shift by BYTE_ENABLE_WIDTH_LOG2).
  - If remaining becomes 0: busy <= 0, done <= 1 for one cycle, go to IDLE. Otherwise go to WAIT_DATA.
  - There is always at least one idle cycle between bursts.
- ctrl_start while busy is ignored.
- Words left in the FIFO after done are kept and feed the next transfer.
- The address wraps modulo 2^ADDRESS_WIDTH. The caller keeps bursts clear of slave page limits.

Test Plan:
- Prefill 8 words 0..7, start base 0x1000, length 8, no waitrequest -> one burst: burstcount 8, address 0x1000, data 0..7 on 8 consecutive cycles. Done pulses once and busy falls in the same cycle.
- Length 20, MAX_BURST 8, data pushed one word every 3 cycles -> bursts of 8, 8, 4 at 0x1000, 0x1020, 0x1040. master_write never asserts before the FIFO holds the full burst.
- waitrequest high for 2 cycles on beats 0 and 5 -> data and address held during each stall. Exactly 8 pops, word order intact.
- 17 pushes into an empty FIFO, depth 16, with no start -> user_full after the 16th push, user_overflow set by the 17th. A later transfer of 16 delivers the first 16 words.
- Start with length 0 -> done high for exactly one cycle, busy 0, master_write never asserted. A start pulse mid-transfer has no effect.
- Assert reset during beat 3 of a burst -> write, busy and burstcount are 0 immediately, the FIFO is empty, and a fresh transfer then runs normally.

Source files
------------

// File: rtl/burst_write_master_fifo.sv
// Avalon-MM burst write master fed by an internal show-ahead FIFO.
// A burst is issued only once the FIFO holds all of its words, so data never stalls mid-burst.
module burst_write_master_fifo #(
    parameter int ADDRESS_WIDTH          = 32,
    parameter int DATA_WIDTH             = 32,
    parameter int BYTE_ENABLE_WIDTH      = 4,
    parameter int BYTE_ENABLE_WIDTH_LOG2 = 2,
    parameter int LENGTH_WIDTH           = 16,
    parameter int MAX_BURST              = 8,
    parameter int BURST_WIDTH            = 4,
    parameter int FIFO_DEPTH             = 16,
    parameter int FIFO_AW                = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic                         master_waitrequest,
    input  logic                         ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
    input  logic [LENGTH_WIDTH-1:0]      ctrl_length,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    input  logic                         user_write,
    input  logic [DATA_WIDTH-1:0]        user_writedata,
    output logic                         user_full,
    output logic                         user_overflow
);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST} state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]          count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
    logic                      write_q, write_d;
    logic [BURST_WIDTH-1:0]    burstcount_q, burstcount_d;
    logic [BURST_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LENGTH_WIDTH-1:0]   remaining_q, remaining_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      full_s, push_s, pop_s;
    logic [LENGTH_WIDTH-1:0]   beats_s;

    assign full_s  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign push_s  = user_write & ~full_s;
    assign pop_s   = write_q & ~master_waitrequest;
    assign beats_s = (remaining_q < LENGTH_WIDTH'(MAX_BURST)) ? remaining_q : LENGTH_WIDTH'(MAX_BURST);

    assign master_address    = address_q;
    assign master_write      = write_q;
    assign master_writedata  = mem_q[rd_ptr_q];
    assign master_burstcount = burstcount_q;
    assign master_byteenable = {BYTE_ENABLE_WIDTH{1'b1}};
    assign ctrl_busy         = busy_q;
    assign ctrl_done         = done_q;
    assign user_full         = full_s;
    assign user_overflow     = overflow_q;

    // FIFO pointer, occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = push_s ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | (user_write & full_s);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Transfer FSM: burst splitting, address advance and completion
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        write_d      = write_q;
        burstcount_d = burstcount_q;
        beat_cnt_d   = beat_cnt_q;
        remaining_d  = remaining_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_start && (ctrl_length != LENGTH_WIDTH'(0))) begin
                    address_d   = ctrl_baseaddress;
                    remaining_d = ctrl_length;
                    busy_d      = 1'b1;
                    state_d     = WAIT_DATA;
                end else if (ctrl_start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_DATA: begin
                if (LENGTH_WIDTH'(count_q) >= beats_s) begin
                    burstcount_d = BURST_WIDTH'(beats_s);
                    beat_cnt_d   = BURST_WIDTH'(beats_s);
                    write_d      = 1'b1;
                    state_d      = BURST;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            BURST: begin
                if (pop_s) begin
                    beat_cnt_d  = beat_cnt_q - BURST_WIDTH'(1);
                    remaining_d = remaining_q - LENGTH_WIDTH'(1);
                    if (beat_cnt_q == BURST_WIDTH'(1)) begin
                        write_d   = 1'b0;
                        address_d = address_q + (ADDRESS_WIDTH'(burstcount_q) << BYTE_ENABLE_WIDTH_LOG2);
                        if (remaining_q == LENGTH_WIDTH'(1)) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    state_d = BURST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= user_writedata;
        end
    end

    // State register with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            address_q    <= '0;
            write_q      <= 1'b0;
            burstcount_q <= '0;
            beat_cnt_q   <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            address_q    <= address_d;
            write_q      <= write_d;
            burstcount_q <= burstcount_d;
            beat_cnt_q   <= beat_cnt_d;
            remaining_q  <= remaining_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_burst_write_master_fifo.sv
// Self-checking bench for burst_write_master_fifo: directed scenarios plus randomized transfers,
// checked against a queue-based model of FIFO contents and the expected burst list.
module tb_burst_write_master_fifo;

    typedef struct {
        logic [31:0] addr;
        int          cnt;
    } burst_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [3:0]  master_burstcount;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest = 1'b0;
    logic        ctrl_start = 1'b0;
    logic [31:0] ctrl_baseaddress = 32'h0;
    logic [15:0] ctrl_length = 16'h0;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        user_write = 1'b0;
    logic [31:0] user_writedata = 32'h0;
    logic        user_full;
    logic        user_overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    burst_t      bq[$];
    int          beat_idx = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          pop_cnt = 0;
    bit          model_ovf = 1'b0;
    bit          model_busy = 1'b0;
    logic        done_prev = 1'b0;
    bit          stall_en = 1'b0;
    bit          rand_wait = 1'b0;
    int          st0 = 0;
    int          st5 = 0;
    bit          hold_valid = 1'b0;
    logic [31:0] hold_data, hold_addr, exp_data;
    bit          full_before;

    burst_write_master_fifo dut (
        .clk               (clk),
        .reset             (reset),
        .master_address    (master_address),
        .master_write      (master_write),
        .master_writedata  (master_writedata),
        .master_burstcount (master_burstcount),
        .master_byteenable (master_byteenable),
        .master_waitrequest(master_waitrequest),
        .ctrl_start        (ctrl_start),
        .ctrl_baseaddress  (ctrl_baseaddress),
        .ctrl_length       (ctrl_length),
        .ctrl_busy         (ctrl_busy),
        .ctrl_done         (ctrl_done),
        .user_write        (user_write),
        .user_writedata    (user_writedata),
        .user_full         (user_full),
        .user_overflow     (user_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor and reference model, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            bq.delete();
            beat_idx   = 0;
            model_ovf  = 1'b0;
            model_busy = 1'b0;
            done_prev  = 1'b0;
            hold_valid = 1'b0;
        end else begin
            full_before = (mq.size() == 16);
            chk("user_full", 64'(user_full), 64'(full_before));
            chk("user_overflow", 64'(user_overflow), 64'(model_ovf));
            chk("byteenable", 64'(master_byteenable), 64'(4'hf));
            if (hold_valid) begin
                chk("stall_hold_data", 64'(master_writedata), 64'(hold_data));
                chk("stall_hold_addr", 64'(master_address), 64'(hold_addr));
            end
            hold_valid = 1'b0;
            if (master_write) begin
                if (bq.size() == 0) begin
                    chk("write_without_burst", 64'(master_write), 64'(0));
                end else begin
                    if (beat_idx == 0)
                        chk("burst_ready", 64'(mq.size() >= int'(master_burstcount)), 64'(1));
                    chk("address", 64'(master_address), 64'(bq[0].addr));
                    chk("burstcount", 64'(master_burstcount), 64'(bq[0].cnt));
                    if (master_waitrequest) begin
                        hold_valid = 1'b1;
                        hold_data  = master_writedata;
                        hold_addr  = master_address;
                    end else begin
                        exp_data = (mq.size() > 0) ? mq[0] : 32'hxxxx_xxxx;
                        chk("writedata", 64'(master_writedata), 64'(exp_data));
                        if (mq.size() > 0) void'(mq.pop_front());
                        pop_cnt++;
                        beat_idx++;
                        if (beat_idx == bq[0].cnt) begin
                            void'(bq.pop_front());
                            beat_idx = 0;
                        end
                    end
                end
            end else if (beat_idx != 0) begin
                chk("burst_gap", 64'(master_write), 64'(1));
            end
            if (ctrl_done) begin
                chk("busy_at_done", 64'(ctrl_busy), 64'(0));
                chk("done_pulse", 64'(done_prev), 64'(0));
                chk("bursts_left_at_done", 64'(bq.size()), 64'(0));
                done_cnt++;
                model_busy = 1'b0;
            end
            done_prev = ctrl_done;
            if (user_write) begin
                if (!full_before) mq.push_back(user_writedata);
                else model_ovf = 1'b1;
            end
        end
    end

    // Slave stall generator
    always @(posedge clk) begin
        #1;
        if (reset) begin
            master_waitrequest = 1'b0;
        end else if (rand_wait) begin
            master_waitrequest = master_write && ($urandom_range(0, 3) == 0);
        end else if (stall_en && master_write && beat_idx == 0 && st0 < 2) begin
            master_waitrequest = 1'b1;
            st0++;
        end else if (stall_en && master_write && beat_idx == 5 && st5 < 2) begin
            master_waitrequest = 1'b1;
            st5++;
        end else begin
            master_waitrequest = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input bit pace);
        int guard = 0;
        while (pace && mq.size() >= 16 && guard < 300) begin
            cyc();
            guard++;
        end
        if (guard >= 300) chk("push_pace_timeout", 64'(user_full), 64'(0));
        user_write     = 1'b1;
        user_writedata = d;
        cyc();
        user_write = 1'b0;
    endtask

    task automatic start(input logic [31:0] base, input int len);
        logic [31:0] a;
        int          rem, c;
        ctrl_baseaddress = base;
        ctrl_length      = 16'(len);
        ctrl_start       = 1'b1;
        if (!model_busy) begin
            exp_done++;
            if (len > 0) begin
                model_busy = 1'b1;
                a   = base;
                rem = len;
                while (rem > 0) begin
                    c = (rem < 8) ? rem : 8;
                    bq.push_back('{a, c});
                    a   = a + 32'(c * 4);
                    rem = rem - c;
                end
            end
        end
        cyc();
        ctrl_start = 1'b0;
        chk("busy_after_start", 64'(ctrl_busy), 64'(model_busy));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt < exp_done && n < budget) begin
            cyc();
            n++;
        end
        cyc();
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        chk("busy_after_done", 64'(ctrl_busy), 64'(0));
    endtask

    initial begin
        int p0, len, n;
        logic [31:0] base;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_address", 64'(master_address), 64'(0));
        chk("rst_write", 64'(master_write), 64'(0));
        chk("rst_burstcount", 64'(master_burstcount), 64'(0));
        chk("rst_busy", 64'(ctrl_busy), 64'(0));
        chk("rst_done", 64'(ctrl_done), 64'(0));
        chk("rst_overflow", 64'(user_overflow), 64'(0));
        chk("rst_full", 64'(user_full), 64'(0));
        reset = 1'b0;
        cyc();

        // Single full burst from prefilled data
        for (int i = 0; i < 8; i++) push_word(32'(i), 1'b1);
        start(32'h1000, 8);
        wait_done(100);

        // Length 20 with slow producer: bursts 8, 8, 4
        start(32'h1000, 20);
        for (int i = 0; i < 20; i++) begin
            push_word($urandom, 1'b1);
            cyc();
            cyc();
        end
        wait_done(200);

        // Stalls on beats 0 and 5
        for (int i = 0; i < 8; i++) push_word($urandom, 1'b1);
        st0 = 0;
        st5 = 0;
        stall_en = 1'b1;
        p0 = pop_cnt;
        start(32'h2000, 8);
        wait_done(100);
        stall_en = 1'b0;
        chk("stall_pop_count", 64'(pop_cnt - p0), 64'(8));
        chk("stall_fifo_empty", 64'(user_full), 64'(0));

        // Overflow: 17 pushes into an empty FIFO, then drain 16
        for (int i = 0; i < 17; i++) begin
            push_word($urandom, 1'b0);
            if (i == 14) chk("full_after_15", 64'(user_full), 64'(0));
            if (i == 15) chk("full_after_16", 64'(user_full), 64'(1));
        end
        chk("overflow_after_17", 64'(user_overflow), 64'(1));
        start(32'h3000, 16);
        wait_done(200);
        chk("overflow_sticky", 64'(user_overflow), 64'(1));

        // Zero-length start and start while busy
        start($urandom & 32'hFFFF_FFFC, 0);
        wait_done(20);
        start(32'h4000, 12);
        for (int i = 0; i < 5; i++) push_word($urandom, 1'b1);
        start(32'h9000, 4);
        for (int i = 0; i < 7; i++) push_word($urandom, 1'b1);
        wait_done(200);

        // Reset during beat 3
        for (int i = 0; i < 8; i++) push_word($urandom, 1'b1);
        start(32'h5000, 8);
        n = 0;
        while (!(master_write && beat_idx == 3) && n < 50) begin
            cyc();
            n++;
        end
        chk("reached_beat3", 64'(beat_idx), 64'(3));
        #2;
        reset = 1'b1;
        #1;
        chk("abort_write", 64'(master_write), 64'(0));
        chk("abort_busy", 64'(ctrl_busy), 64'(0));
        chk("abort_burstcount", 64'(master_burstcount), 64'(0));
        chk("abort_done", 64'(ctrl_done), 64'(0));
        cyc();
        reset = 1'b0;
        exp_done = done_cnt;
        chk("abort_overflow_clr", 64'(user_overflow), 64'(0));
        for (int i = 0; i < 3; i++) push_word($urandom, 1'b1);
        start(32'h6000, 3);
        wait_done(100);

        // Randomized transfers, including one across the address wrap
        rand_wait = 1'b1;
        for (int t = 0; t < 4; t++) begin
            base = (t == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            len  = $urandom_range(1, 40);
            start(base, len);
            for (int i = 0; i < len; i++) begin
                push_word($urandom, 1'b1);
                repeat ($urandom_range(0, 3)) cyc();
            end
            wait_done(3000);
        end
        rand_wait = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
